// File: rtl/vga_rect_fill_master.sv
// vga_rect_fill_master: clips one rectangle fill command to the 640x480
// visible area and writes it pixel by pixel, row-major, to the display
// device write port, stalling while the device reports busy.
// Optional build macro: VGA_RECT_FILL_CLEAR_SHORTCUT_EN turns a full-screen
// fill from the origin into a single write of the display clear command.
module vga_rect_fill_master #(
  parameter logic [31:0] PIXEL_BASE = 32'h0000_0100,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iCMD_REQ,
  output logic        oCMD_BUSY,
  input  logic [9:0]  iCMD_X0,
  input  logic [9:0]  iCMD_Y0,
  input  logic [9:0]  iCMD_W,
  input  logic [9:0]  iCMD_H,
  input  logic [11:0] iCMD_COLOR,
  output logic        oDONE,
  output logic        oDISP_REQ,
  input  logic        iDISP_BUSY,
  output logic        oDISP_RW,
  output logic [31:0] oDISP_ADDR,
  output logic [31:0] oDISP_DATA
);

  localparam logic [10:0] H_RES11  = 11'(H_RES);
  localparam logic [10:0] V_RES11  = 11'(V_RES);
  localparam logic [31:0] ROW_STEP = 32'(H_RES * 4);

  typedef enum logic [1:0] {IDLE, CLIP, RUN, DONE} state_t;

  state_t state, nextState;

  logic [9:0]  x0Reg, y0Reg, wReg, hReg;
  logic [11:0] colorReg;
  logic [9:0]  x, y;
  logic [10:0] xLast, yLast;
  logic [31:0] rowBase, addr;

  logic        cmdAccept, xfer, emptyRect, moreX, moreY;
  logic [10:0] xEnd, yEnd, xClip, yClip;
  logic [31:0] rowBaseInit;

  assign cmdAccept = iCMD_REQ && (state == IDLE);
  assign xfer      = (state == RUN) && !iDISP_BUSY;
  assign moreX     = {1'b0, x} < xLast;
  assign moreY     = {1'b0, y} < yLast;

  // Clip arithmetic is done in 11 bits so X0+W / Y0+H cannot wrap.
  always_comb begin
    xEnd        = {1'b0, x0Reg} + {1'b0, wReg};
    yEnd        = {1'b0, y0Reg} + {1'b0, hReg};
    xClip       = (xEnd > H_RES11) ? H_RES11 : xEnd;
    yClip       = (yEnd > V_RES11) ? V_RES11 : yEnd;
    emptyRect   = (wReg == '0) || (hReg == '0) ||
                  ({1'b0, x0Reg} >= H_RES11) || ({1'b0, y0Reg} >= V_RES11);
    rowBaseInit = PIXEL_BASE +
                  ((32'(y0Reg) * 32'(H_RES) + 32'(x0Reg)) << 2);
  end

`ifdef VGA_RECT_FILL_CLEAR_SHORTCUT_EN
  logic fullScreen;
  assign fullScreen = (x0Reg == '0) && (y0Reg == '0) &&
                      ({1'b0, wReg} >= H_RES11) && ({1'b0, hReg} >= V_RES11);
`endif

  // State register; either reset abandons any fill in progress.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)         state <= IDLE;
    else if (iRESET_SYNC) state <= IDLE;
    else                  state <= nextState;
  end

  // Next-state selection.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (cmdAccept) nextState = CLIP;
      CLIP: nextState = emptyRect ? DONE : RUN;
      RUN:  if (xfer && !moreX && !moreY) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Command latch, clip setup and pixel walk counters.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      x0Reg <= '0; y0Reg <= '0; wReg <= '0; hReg <= '0; colorReg <= '0;
      x <= '0; y <= '0; xLast <= '0; yLast <= '0;
      rowBase <= '0; addr <= '0;
    end else if (iRESET_SYNC) begin
      x0Reg <= '0; y0Reg <= '0; wReg <= '0; hReg <= '0; colorReg <= '0;
      x <= '0; y <= '0; xLast <= '0; yLast <= '0;
      rowBase <= '0; addr <= '0;
    end else begin
      if (cmdAccept) begin
        x0Reg    <= iCMD_X0;
        y0Reg    <= iCMD_Y0;
        wReg     <= iCMD_W;
        hReg     <= iCMD_H;
        colorReg <= iCMD_COLOR;
      end
      if (state == CLIP) begin
        x       <= x0Reg;
        y       <= y0Reg;
        xLast   <= xClip - 11'd1;
        yLast   <= yClip - 11'd1;
        rowBase <= rowBaseInit;
        addr    <= rowBaseInit;
`ifdef VGA_RECT_FILL_CLEAR_SHORTCUT_EN
        // Collapsing the walk to a 1x1 region at (0,0) makes RUN issue
        // exactly one write, which goes to the clear-command address.
        if (fullScreen) begin
          xLast <= '0;
          yLast <= '0;
          addr  <= '0;
        end
`endif
      end else if (xfer) begin
        if (moreX) begin
          x    <= x + 10'd1;
          addr <= addr + 32'd4;
        end else if (moreY) begin
          x       <= x0Reg;
          y       <= y + 10'd1;
          rowBase <= rowBase + ROW_STEP;
          addr    <= rowBase + ROW_STEP;
        end
      end
    end
  end

  assign oCMD_BUSY  = (state != IDLE);
  assign oDONE      = (state == DONE);
  assign oDISP_REQ  = (state == RUN);
  assign oDISP_RW   = 1'b1;
  assign oDISP_ADDR = addr;
  assign oDISP_DATA = {20'h0, colorReg};

endmodule

// File: doc/vga_rect_fill_master.md
# vga_rect_fill_master

Bus-initiator rectangle fill engine for the 640x480 display device. It accepts one fill command (origin, size, 12-bit colour), clips it to the visible area, and issues one pixel write per accepted transfer to the display device's write port, honouring that port's busy handshake. It sits between the CPU-side command registers and the display device's iDEV_REQ/oDEV_BUSY write path, offloading block fills from the CPU.

## Interface
- PIXEL_BASE, 32'h0000_0100, byte address of pixel (0,0) in display space
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- iCLOCK  in  1  system clock
- inRESET  in  1  asynchronous reset, active-low
- iRESET_SYNC  in  1  synchronous reset, active-high; same effect as inRESET
- iCMD_REQ  in  1  command valid
- oCMD_BUSY  out  1  engine busy; a command is accepted only when iCMD_REQ && !oCMD_BUSY
- iCMD_X0 / iCMD_Y0  in  10 each  rectangle origin
- iCMD_W / iCMD_H  in  10 each  rectangle width/height in pixels
- iCMD_COLOR  in  12  colour, 4R4G4B
- oDONE  out  1  one-cycle pulse when a command completes
- oDISP_REQ  out  1  write request to display device
- iDISP_BUSY  in  1  display device busy
- oDISP_RW  out  1  always 1 (write)
- oDISP_ADDR  out  32  byte address
- oDISP_DATA  out  32  {20'h0, colour}

## Operation
- Reset: inRESET or iRESET_SYNC forces IDLE; oCMD_BUSY=0, oDONE=0, oDISP_REQ=0, oDISP_RW=1, oDISP_ADDR=0, oDISP_DATA=0. Reset mid-fill abandons the fill immediately; no further writes and no oDONE.
- States: IDLE -> CLIP -> RUN -> DONE -> IDLE; CLIP -> DONE for empty rectangles.
- IDLE: on acceptance, latch X0, Y0, W, H, colour; go to CLIP.
- CLIP: empty if W==0, H==0, X0>=H_RES or Y0>=V_RES. Otherwise x_last = min(X0+W, H_RES)-1 and y_last = min(Y0+H, V_RES)-1, computed in 11 bits (no overflow). Row base = PIXEL_BASE + ((Y0*H_RES + X0) << 2). Go to RUN.
- RUN: oDISP_REQ=1, oDISP_ADDR = current address, oDISP_DATA = {20'h0, colour}. A transfer occurs on a cycle with oDISP_REQ && !iDISP_BUSY. On transfer: if x<x_last then x++, addr+=4; else if y<y_last then x=X0, y++, row base += H_RES*4, addr = new row base; else go to DONE. Order is row-major, left to right, top to bottom.
- DONE: oDONE=1 for one cycle, oDISP_REQ=0; go to IDLE.
- oCMD_BUSY=1 in CLIP, RUN and DONE. Commands offered while busy are ignored and are not queued.

## Timing
- Command accepted in cycle 0. CLIP occupies cycle 1. First oDISP_REQ is asserted in cycle 2.
- Throughput is one pixel per cycle while iDISP_BUSY=0.
- While iDISP_BUSY=1, oDISP_REQ, oDISP_ADDR and oDISP_DATA hold stable and the counters do not advance.
- oDONE asserts the cycle after the last transfer. For an empty rectangle, oDONE asserts in cycle 2 with no request.
- oCMD_BUSY drops in the cycle after oDONE, so the earliest next acceptance is that cycle.
- iDISP_BUSY rising in the same cycle as a request counts as no transfer, and the request is retried.

## Configuration
- VGA_RECT_FILL_CLEAR_SHORTCUT_EN defined: in CLIP, a command with X0=0, Y0=0, W>=H_RES and H>=V_RES instead issues a single write to address 32'h0 (the display clear command) with data {20'h0, colour}, then goes to DONE. Handshake and timing are unchanged.
- Not defined: every command, including full-screen commands, performs the per-pixel fill.

## Test plan
- (10,20) W=2 H=2, colour 0xF00, BUSY=0 -> four writes of data 0x00000F00 to 0xC928, 0xC92C, 0xD328, 0xD32C on cycles 2-5; oDONE on cycle 6.
- Same command with iDISP_BUSY high for 3 cycles during the second write -> address 0xC92C and its data hold for 4 cycles; exactly 4 transfers total; oDONE delayed by 3 cycles.
- (638,479) W=5 H=3 -> exactly 2 writes, to 0x12C0F8 and 0x12C0FC; then oDONE.
- W=0, or X0=640 -> no oDISP_REQ; oDONE in cycle 2; a new command issued while busy is ignored.
- (0,0) W=640 H=480, colour 0xABC: with the macro defined -> one write, addr 0x0, data 0x00000ABC. Without the macro -> 307200 writes, first at 0x100, last at 0x12C0FC.
- Assert iRESET_SYNC mid-RUN -> oDISP_REQ=0 and oCMD_BUSY=0 in the next cycle, no oDONE; a following command runs correctly.
